// File: rtl/led_status_ctrl.sv
// ============================================================================
// Module   : led_status_ctrl
// Purpose  : Registered four-state front-panel red/green status LED controller
//            with blink divider, activity stretch and error display.
// Options  : LED_ERROR_LATCH_EN - sticky error flag instead of the timed hold
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_status_ctrl #(
   parameter int NUM_BUSY        = 2,
   parameter int BLINK_BITS      = 24,
   parameter int STRETCH_CYCLES  = 1000000,
   parameter int ERR_HOLD_CYCLES = 4000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                aurora_channel_up,
   input  logic [NUM_BUSY-1:0] sm_idle,
   input  logic                activity,
   input  logic                error_pulse,
   input  logic                error_clear,
   output logic                red_led,
   output logic                green_led,
   output logic [1:0]          status,
   output logic [7:0]          err_count
);

   localparam int c_STRETCH_W = $clog2(STRETCH_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_LINK_DOWN = 2'b00,
      ST_BUSY      = 2'b01,
      ST_READY     = 2'b10,
      ST_ERROR     = 2'b11
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [BLINK_BITS-1:0]  r_div;
   logic                   r_phase;
   logic                   r_valid;
   logic [c_STRETCH_W-1:0] r_stretch;
   logic [7:0]             r_err_count;
   logic                   r_red;
   logic                   r_green;
   logic                   w_red_next;
   logic                   w_green_next;
   logic                   w_err_active;

`ifdef LED_ERROR_LATCH_EN
   logic r_err_flag;
   logic w_err_flag_next;

   // A pulse in the same cycle as a clear wins so no event is lost.
   always_comb begin
      w_err_flag_next = r_err_flag;
      if (error_pulse)
         w_err_flag_next = 1'b1;
      else if (error_clear)
         w_err_flag_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_flag <= 1'b0;
      else
         r_err_flag <= w_err_flag_next;
   end

   assign w_err_active = w_err_flag_next;
`else
   localparam int c_ERR_W = $clog2(ERR_HOLD_CYCLES + 1);

   logic [c_ERR_W-1:0] r_err_timer;
   logic [c_ERR_W-1:0] w_err_timer_next;

   always_comb begin
      w_err_timer_next = r_err_timer;
      if (error_pulse)
         w_err_timer_next = c_ERR_W'(ERR_HOLD_CYCLES);
      else if (error_clear)
         w_err_timer_next = '0;
      else if (r_err_timer != '0)
         w_err_timer_next = r_err_timer - c_ERR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_timer <= '0;
      else
         r_err_timer <= w_err_timer_next;
   end

   assign w_err_active = (w_err_timer_next != '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div     <= '0;
         r_stretch <= '0;
      end else begin
         r_div <= r_div + BLINK_BITS'(1);
         if (activity)
            r_stretch <= c_STRETCH_W'(STRETCH_CYCLES);
         else if (r_stretch != '0)
            r_stretch <= r_stretch - c_STRETCH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_count <= 8'd0;
      else if (error_clear)
         r_err_count <= {7'd0, error_pulse};
      else if (error_pulse && (r_err_count != 8'hFF))
         r_err_count <= r_err_count + 8'd1;
   end

   // State and phase register together so the LED stage sees a coherent pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LINK_DOWN;
         r_phase <= 1'b0;
         r_valid <= 1'b0;
         r_red   <= 1'b1;
         r_green <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_phase <= r_div[BLINK_BITS-1];
         r_valid <= 1'b1;
         r_red   <= w_red_next;
         r_green <= w_green_next;
      end
   end

   always_comb begin
      w_state_next = ST_READY;
      if (w_err_active)
         w_state_next = ST_ERROR;
      else if (!aurora_channel_up)
         w_state_next = ST_LINK_DOWN;
      else if (!(&sm_idle))
         w_state_next = ST_BUSY;
   end

   // LEDs are active-low; the first cycle after reset keeps both dark.
   always_comb begin
      w_red_next   = 1'b1;
      w_green_next = 1'b1;
      if (r_valid) begin
         case (r_state)
            ST_LINK_DOWN: w_red_next = r_phase;
            ST_BUSY:      w_red_next = 1'b0;
            ST_READY:     w_green_next = (r_stretch != '0);
            ST_ERROR: begin
               w_red_next   = r_phase;
               w_green_next = ~r_phase;
            end
            default: ;
         endcase
      end
   end

   assign red_led   = r_red;
   assign green_led = r_green;
   assign status    = r_state;
   assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
// ============================================================================
// Module   : tb_led_status_ctrl
// Purpose  : Self-checking bench for led_status_ctrl against a history model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_status_ctrl;

   localparam int BB    = 4;
   localparam int SC    = 5;
   localparam int EH    = 8;
   localparam int NB    = 2;
   localparam int HSIZE = 8192;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          link = 1'b0;
   logic [NB-1:0] idle = '1;
   logic          act = 1'b0;
   logic          ep = 1'b0;
   logic          ec = 1'b0;
   logic          red_led, green_led;
   logic [1:0]    status;
   logic [7:0]    err_count;

   int vectors = 0;
   int errors  = 0;
   int n       = 0;

   bit          link_h [HSIZE];
   bit [NB-1:0] idle_h [HSIZE];
   bit          act_h  [HSIZE];
   bit          ep_h   [HSIZE];
   bit          ec_h   [HSIZE];
   bit [7:0]    cnt_h  [HSIZE];

   logic [11:0] got, exp;

   led_status_ctrl #(
      .NUM_BUSY(NB), .BLINK_BITS(BB), .STRETCH_CYCLES(SC), .ERR_HOLD_CYCLES(EH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .aurora_channel_up(link), .sm_idle(idle),
      .activity(act), .error_pulse(ep), .error_clear(ec),
      .red_led(red_led), .green_led(green_led), .status(status), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Stretch active after edge m: some strobe within the last SC edges.
   function automatic bit stretch_nz(int m);
      for (int j = m; j >= 1 && j > m - SC; j--)
         if (act_h[j]) return 1'b1;
      return 1'b0;
   endfunction

   // Error active after edge m: most recent pulse/clear event decides.
   function automatic bit err_act(int m);
      for (int j = m; j >= 1; j--) begin
         if (ep_h[j]) begin
`ifdef LED_ERROR_LATCH_EN
            return 1'b1;
`else
            return (m - j) < EH;
`endif
         end
         if (ec_h[j]) return 1'b0;
      end
      return 1'b0;
   endfunction

   function automatic logic [1:0] st(int m);
      if (m < 1)              return 2'b00;
      if (err_act(m))         return 2'b11;
      if (!link_h[m])         return 2'b00;
      if (idle_h[m] != '1)    return 2'b01;
      return 2'b10;
   endfunction

   // Expected {red, green, status, err_count} observed just after edge m.
   function automatic logic [11:0] exp_out(int m);
      logic r, g, ph;
      r = 1'b1;
      g = 1'b1;
      if (m >= 2) begin
         ph = (((m - 2) / (2 ** (BB - 1))) % 2) == 1;
         case (st(m - 1))
            2'b00: r = ph;
            2'b01: r = 1'b0;
            2'b10: g = stretch_nz(m - 1);
            default: begin r = ph; g = ~ph; end
         endcase
      end
      return {r, g, st(m), cnt_h[m]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      link = 1'b0; idle = '1; act = 1'b0; ep = 1'b0; ec = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      cnt_h[0] = 8'd0;
   endtask

   task automatic drive(input bit lk, input bit [NB-1:0] id, input bit ac,
                        input bit p, input bit c);
      link = lk; idle = id; act = ac; ep = p; ec = c;
      @(posedge clk);
      n++;
      link_h[n] = lk; idle_h[n] = id; act_h[n] = ac; ep_h[n] = p; ec_h[n] = c;
      if (c)
         cnt_h[n] = {7'd0, p};
      else if (p && cnt_h[n-1] != 8'd255)
         cnt_h[n] = cnt_h[n-1] + 8'd1;
      else
         cnt_h[n] = cnt_h[n-1];
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      got = {red_led, green_led, status, err_count};
      vectors++;
      if (got !== 12'hC00) begin
         errors++;
         $display("FAIL reset_hold: got %h expected %h", got, 12'hC00);
      end
      rst_n = 1'b1;
      n = 0;
      cnt_h[0] = 8'd0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL link_down_blink cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   task automatic test_ready_busy();
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, (i < 6) ? 2'b11 : 2'b01, 1'b0, 1'b0, 1'b0);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL ready_busy cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   task automatic test_activity();
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 2'b11, (i == 3) || (i == 6), 1'b0, 1'b0);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL activity_stretch cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   task automatic test_error();
      bit p, c;
      for (int i = 0; i < 44; i++) begin
`ifdef LED_ERROR_LATCH_EN
         p = (i == 0) || (i == 2) || (i == 4) || (i == 30);
         c = (i == 24) || (i == 30);
`else
         p = (i == 0) || (i == 14) || (i == 30);
         c = (i == 17) || (i == 30);
`endif
         drive(1'b1, 2'b11, 1'b0, p, c);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL error_display cyc %0d: got %h expected %h", n, got, exp);
         end
         vectors++;
         if (!red_led && !green_led) begin
            errors++;
            $display("FAIL both_leds_on cyc %0d: got red=%b green=%b", n, red_led, green_led);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 310; i++) begin
         drive(1'b1, 2'b11, 1'b0, i < 300, i == 305);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL err_saturate cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 99) < 85, NB'($urandom), $urandom_range(0, 99) < 12,
               $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL random cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 13; i++)
         drive(1'b1, 2'b11, i == 9, i < 2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      got = {red_led, green_led, status, err_count};
      vectors++;
      if (got !== 12'hC00) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", got, 12'hC00);
      end
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
         got = {red_led, green_led, status, err_count};
         exp = exp_out(n);
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL post_reset cyc %0d: got %h expected %h", n, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ready_busy();
      test_activity();
      test_error();
      test_saturation();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised front-panel LED controller driving the red/green status LED pair of the card. It replaces the purely combinational ready/busy indication with a registered four-state status machine. Link-down is shown as a red blink, errors as an alternating red/green pattern, and data activity as a stretched flicker on green. It sits at the top level beside the Aurora core and the acquisition/command state machines.

## Interface
- NUM_BUSY, 2: number of state-machine idle flags combined into "busy".
- BLINK_BITS, 24: width of the free-running blink divider; blink phase = divider MSB.
- STRETCH_CYCLES, 1000000: green-off time after an activity pulse (≥1).
- ERR_HOLD_CYCLES, 4000000: error display time when error latching is compiled out (≥1).

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- aurora_channel_up  in  1  Aurora channel up.
- sm_idle  in  NUM_BUSY  per-state-machine idle flags; busy = any bit 0.
- activity  in  1  single-cycle data-activity strobe.
- error_pulse  in  1  single-cycle error event.
- error_clear  in  1  clears error indication and error count.
- red_led  out  1  active-low (0 = on).
- green_led  out  1  active-low (0 = on).
- status  out  2  current state: 00 LINK_DOWN, 01 BUSY, 10 READY, 11 ERROR.
- err_count  out  8  saturating error-event counter.

## Operation
- Blink divider: BLINK_BITS-bit up-counter, wraps, runs in every state; phase = cnt[BLINK_BITS-1].
- State priority, evaluated every cycle: ERROR (error active) > LINK_DOWN (!aurora_channel_up) > BUSY (any sm_idle bit 0) > READY.
  - Any state may move to any other state in one cycle.
  - There are no sticky states other than the error condition.
- LED decode, from registered state:
  - LINK_DOWN: red on while phase=0, green off.
  - BUSY: red on, green off.
  - READY: red off; green on unless the stretch counter is nonzero.
  - ERROR: red on while phase=0, green on while phase=1; never both on at once.
- Activity stretch: an activity strobe loads the stretch counter with STRETCH_CYCLES.
  - The counter decrements to 0 and retriggers (reloads) on every strobe.
  - It counts in all states but only affects the LEDs in READY.
- err_count increments on each error_pulse and saturates at 255.
  - error_clear sets it to 0.
  - If error_clear and error_pulse arrive in the same cycle, the result is 1.
- Error active: defined under Configuration.
- Simultaneous error_pulse and error_clear: the error stays active, so set wins and no event is lost.

## Timing
- Reset values (asserted asynchronously): status=00 (LINK_DOWN), red_led=1, green_led=1, err_count=0, divider=0, stretch=0, error state cleared.
- Latency: state registers 1 cycle after the input change; LEDs register 1 cycle after state. Input to LED is 2 cycles.
- After rst_n deasserts with the link down, red_led goes 0 on the 2nd clock edge, since phase=0 then.
- Activity in READY: green_led goes 1 two cycles after the strobe. It stays 1 for STRETCH_CYCLES cycles after the last strobe, then returns to 0.
- Blink period is 2^BLINK_BITS cycles with 50% duty.
- Reset mid-blink or mid-stretch: all counters clear immediately and no residual pulse appears after release.

## Configuration
- LED_ERROR_LATCH_EN defined:
  - error_pulse sets a sticky error flag, and ERROR persists until error_clear.
  - With error_clear and error_pulse in the same cycle, the flag stays set.
- LED_ERROR_LATCH_EN undefined:
  - error_pulse loads an error timer with ERR_HOLD_CYCLES, and ERROR is active while the timer is nonzero.
  - A new pulse retriggers the timer.
  - error_clear zeroes the timer unless a pulse arrives in the same cycle.

## Test plan
Parameters for all scenarios: BLINK_BITS=4, STRETCH_CYCLES=5, ERR_HOLD_CYCLES=8, NUM_BUSY=2.
- Reset release, link down: status=00; red_led toggles every 8 cycles starting 0 at cycle 2; green_led=1 throughout.
- Link up, sm_idle=2'b11: status=10 two cycles later; green_led=0, red_led=1. Then sm_idle=2'b01: status=01, red_led=0, green_led=1.
- Activity stretch in READY: strobe at t0 gives green_led=1 from t0+2 to t0+6. A second strobe at t0+3 extends this to t0+9.
- Latched error (macro defined): error_pulse ×3 gives err_count=3, status=11, red and green alternating, never both 0. error_clear returns the block to READY. Pulse and clear in the same cycle give status=11 and err_count=1.
- Timed error (macro undefined): a single error_pulse shows ERROR for 8 cycles, then READY. err_count saturates at 255 after 300 pulses.
- Asynchronous rst_n assertion mid-ERROR: both LEDs=1, status=00 and err_count=0 immediately, without waiting for a clock edge.
